// File: rtl/parity_link_pkg.sv
// rtl/parity_link_pkg.sv - shared types, line constants and parity helper for the XOR-parity serial link
package parity_link_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Widest legal payload is 16 bits; narrower words are zero-extended by the caller.
    function automatic logic parity_of(input logic [15:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/parity_accum.sv
// rtl/parity_accum.sv - 1-bit running XOR accumulator shared by link receiver and transmitter
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - framed serial receiver with parity/framing checks; PARITY_RX_ERRCNT_EN adds err_count
module serial_parity_rx
    import parity_link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
`ifdef PARITY_RX_ERRCNT_EN
    output logic              busy,
    output logic [7:0]        err_count
`else
    output logic              busy
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              mismatch;
    logic              acc;
    logic              start_seen;
    logic              data_en;
    logic              stop_seen;
    logic              stop_bad;

    assign start_seen = rx_valid && (state == RX_IDLE) && (rx_bit == START_BIT);
    assign data_en    = rx_valid && (state == RX_DATA);
    assign stop_seen  = rx_valid && (state == RX_STOP);
    assign stop_bad   = (rx_bit != STOP_BIT);

    parity_accum u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_seen),
        .en     (data_en),
        .bit_in (rx_bit),
        .acc    (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            mismatch   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Flags are pulses qualified by data_valid, so they drop every cycle by default.
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_valid) begin
                case (state)
                    RX_IDLE: begin
                        if (rx_bit == START_BIT) begin
                            state     <= RX_DATA;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_reg[bit_cnt] <= rx_bit;
                        bit_cnt            <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        mismatch <= acc ^ rx_bit ^ ODD_PARITY;
                        state    <= RX_STOP;
                    end
                    default: begin
                        data_valid <= 1'b1;
                        data_out   <= shift_reg;
                        parity_err <= mismatch;
                        frame_err  <= stop_bad;
                        busy       <= 1'b0;
                        state      <= RX_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PARITY_RX_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (stop_seen && (mismatch || stop_bad) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb/tb_serial_parity_rx.sv - scoreboard bench for serial_parity_rx (even and odd parity instances)
module tb_serial_parity_rx;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_bit;
    logic       rx_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;
    logic [7:0] o_data_out;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;
    logic [7:0] o_err_count;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_cnt  = 0;
    logic       prev_dv  = 1'b0;
    int         odd_seen = 0;
    logic [7:0] odd_data;
    logic       odd_perr;
    logic       odd_ferr;

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
`ifdef PARITY_RX_ERRCNT_EN
        .err_count  (err_count),
`endif
        .busy       (busy)
    );

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .data_out   (o_data_out),
        .data_valid (o_data_valid),
        .parity_err (o_parity_err),
        .frame_err  (o_frame_err),
`ifdef PARITY_RX_ERRCNT_EN
        .err_count  (o_err_count),
`endif
        .busy       (o_busy)
    );

`ifndef PARITY_RX_ERRCNT_EN
    assign err_count   = 8'd0;
    assign o_err_count = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every data_valid pops one expected frame.
    always @(negedge clk) begin
        if (data_valid) begin
            exp_t e;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_dv: data_out=%h with no frame outstanding", data_out);
            end else begin
                e = q.pop_front();
                if (data_out !== e.data || parity_err !== e.perr || frame_err !== e.ferr) begin
                    n_fail++;
                    $display("FAIL frame: got data=%h perr=%b ferr=%b, want data=%h perr=%b ferr=%b",
                             data_out, parity_err, frame_err, e.data, e.perr, e.ferr);
                end
            end
            n_checks++;
            if (prev_dv !== 1'b0) begin
                n_fail++;
                $display("FAIL dv_pulse: data_valid high %b cycles in a row, want single pulse", prev_dv);
            end
        end else begin
            n_checks++;
            if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL flags_unqualified: perr=%b ferr=%b without data_valid, want 0 0",
                         parity_err, frame_err);
            end
        end
        prev_dv <= data_valid;
    end

    always @(negedge clk) begin
        if (o_data_valid) begin
            odd_seen++;
            odd_data = o_data_out;
            odd_perr = o_parity_err;
            odd_ferr = o_frame_err;
        end
    end

    task automatic send_bit(input logic b, input int gap);
        rx_bit   = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_bit   = 1'b1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int maxgap);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ pbit;
        e.ferr = ~sbit;
        q.push_back(e);
        if ((e.perr || e.ferr) && exp_cnt < 255) exp_cnt++;
        send_bit(1'b0, pick_gap(maxgap));
        for (int i = 0; i < 8; i++) send_bit(d[i], pick_gap(maxgap));
        send_bit(pbit, pick_gap(maxgap));
        send_bit(sbit, 0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d frames outstanding, want 0", name, q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name);
`ifdef PARITY_RX_ERRCNT_EN
        n_checks++;
        if (err_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s_err_count: got %0d want %0d", name, err_count, exp_cnt);
        end
`endif
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || parity_err !== 1'b0 ||
            frame_err !== 1'b0 || busy !== 1'b0 || err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: data=%h dv=%b perr=%b ferr=%b busy=%b cnt=%0d, want all 0",
                     name, data_out, data_valid, parity_err, frame_err, busy, err_count);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame;
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        wait_drain("good");
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_parity_error;
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        wait_drain("parity_err");
        check_cnt("parity_err");
    endtask

    task automatic test_framing_error;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        wait_drain("framing");
        check_cnt("framing");
    endtask

    task automatic test_idle_and_gaps;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 0);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_busy: got %b want 0 after idle bit %0d", busy, i);
            end
        end
        send_frame(8'h5A, 1'b0, 1'b1, 3);
        send_frame(8'h5A, 1'b1, 1'b1, 3);
        wait_drain("gaps");
    endtask

    task automatic test_reset_mid_frame;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_idle_outputs("midframe_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        wait_drain("after_reset");
        check_cnt("after_reset");
    endtask

    task automatic test_odd_parity;
        int seen0;
        seen0 = odd_seen;
        send_frame(8'h00, 1'b1, 1'b1, 0);
        wait_drain("odd0");
        n_checks++;
        if (odd_seen != seen0 + 1 || odd_data !== 8'h00 || odd_perr !== 1'b0 || odd_ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_00: got n=%0d data=%h perr=%b ferr=%b, want n=%0d data=00 perr=0 ferr=0",
                     odd_seen - seen0, odd_data, odd_perr, odd_ferr, 1);
        end
        send_frame(8'h01, 1'b1, 1'b1, 0);
        wait_drain("odd1");
        n_checks++;
        if (odd_seen != seen0 + 2 || odd_data !== 8'h01 || odd_perr !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_01: got n=%0d data=%h perr=%b, want n=2 data=01 perr=1",
                     odd_seen - seen0, odd_data, odd_perr);
        end
    endtask

    task automatic test_saturation;
`ifdef PARITY_RX_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            send_frame(8'(i), ~(^8'(i)), 1'b1, 0);
            if (i == 100) check_cnt("sat_mid");
        end
        wait_drain("saturation");
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: got %0d want 255", err_count);
        end
`else
        for (int i = 0; i < 4; i++) send_frame(8'(i * 37), ~(^8'(i * 37)), 1'b1, 0);
        wait_drain("err_frames");
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_bit   = 1'b1;
        rx_valid = 1'b0;
        test_reset;
        test_good_frame;
        test_parity_error;
        test_framing_error;
        test_idle_and_gaps;
        test_reset_mid_frame;
        test_odd_parity;
        test_saturation;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Receive end of the team's XOR-parity serial link: deserialises a framed bitstream, recomputes parity with a running XOR and flags parity and framing errors.
- Sits behind the bit-level line interface, which delivers one sampled bit per rx_valid strobe.
- Delivers parallel words plus error status to downstream logic.

Parameters:
- DATA_W, 8, payload bits per frame (legal 1..16).
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_bit  in  1  serial line value; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe marking rx_bit as a new bit.
- data_out  out  DATA_W  last received payload; held until the next frame completes.
- data_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  parity mismatch; qualified by data_valid.
- frame_err  out  1  stop bit read as 0; qualified by data_valid.
- busy  out  1  high from start-bit acceptance until frame completion.
- err_count  out  8  saturating error count (only with PARITY_RX_ERRCNT_EN).

Behaviour:
- Interface is fixed: single clock clk; reset rst_n is asynchronous and active-low.
- Frame format: start bit (0), DATA_W data bits LSB first, 1 parity bit, stop bit (1).
- Reset values:
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0.
  - FSM in IDLE; bit counter and parity accumulator cleared.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: rx_valid&&rx_bit==0 -> DATA; clear shift register, bit counter and accumulator; busy=1 next cycle. rx_valid&&rx_bit==1 is ignored (line idle).
  - DATA: on each rx_valid, shift rx_bit into position bit_cnt and XOR it into the accumulator. After the DATA_W-th bit -> PARITY.
  - PARITY: on rx_valid, compute mismatch = acc ^ rx_bit ^ ODD_PARITY; latch mismatch internally -> STOP.
  - STOP: on rx_valid, latch frame_err = ~rx_bit -> IDLE.
- Cycles without rx_valid never advance state. Gaps of any length are legal.
- Latency: data_valid, data_out, parity_err and frame_err update on the clock edge after the stop-bit sample; busy falls on that same edge. Outputs are registered.
- data_valid pulses for exactly one cycle, even when an error is flagged; the errored payload is still presented.
- Error flags are valid only while data_valid=1 and read 0 otherwise.
- A start bit sampled in the cycle immediately after data_valid is accepted with no dead time.
- Reset asserted mid-frame aborts the frame: no data_valid, all outputs return to reset values.
- No break detection: a stop bit of 0 only sets frame_err. The next 0 sampled in IDLE is treated as a start bit.

Optional Feature:
- Macro: PARITY_RX_ERRCNT_EN.
- Defined:
  - err_count port exists.
  - Increments by 1 on each data_valid where parity_err|frame_err; a frame with both errors counts once.
  - Saturates at 255; cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package parity_link_pkg holds:
  - FSM state enum rx_state_t;
  - START_BIT=1'b0 and STOP_BIT=1'b1 constants;
  - function parity_of(vector), XOR reduction, shared with the transmit side.
- One natural sub-module, parity_accum:
  - 1-bit XOR accumulator with clear and enable inputs and output acc;
  - reused by the matching transmitter.

Test Plan:
- Good frame: DATA_W=8, even parity, bits 0,1,0,1,0,0,1,0,1,0,1 (payload 0xA5, parity 0, stop 1), each with rx_valid -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low after.
- Parity error: same frame with parity bit 1 -> data_out=0xA5, data_valid=1, parity_err=1, frame_err=0; with the macro defined, err_count=1.
- Framing error: payload 0x3C, parity 0, stop bit 0 -> frame_err=1, parity_err=0. A following start bit starts a new frame.
- Strobe gaps and idle line:
  - Eight rx_valid pulses with rx_bit=1 in IDLE -> busy stays 0, no data_valid.
  - Then 0x5A sent with 0–3 idle cycles between bits -> data_out=0x5A with correct flags.
- Reset mid-frame: assert rst_n=0 after 4 data bits -> all outputs 0, no data_valid. A full good frame 0xFF afterwards is received cleanly.
- Odd parity and saturation:
  - ODD_PARITY=1, payload 0x00 with parity 1 -> no error.
  - With the macro defined, 300 consecutive parity-error frames -> err_count=255.
